// File: rtl/uart_pkg.sv
// uart_pkg: baud defaults and frame FSM states shared by both UART directions
package uart_pkg;
    localparam int CLOCKS_PER_BAUD_DEF = 868;
    localparam int TIMER_BITS_DEF = 32;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: small power-of-two byte FIFO with occupancy count and async active-low reset
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rp];
    always_ff @(posedge clk or negedge i_reset_n)
        if (!i_reset_n) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= do_push ? wp + 1'b1 : wp;
            rp <= do_pop ? rp + 1'b1 : rp;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    // storage needs no reset: pointers alone define which entries are live
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/tx_uart.sv
// tx_uart: FIFO-buffered UART transmitter, LSB-first frames with configurable data/stop bits
module tx_uart
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int TIMER_BITS = TIMER_BITS_DEF,
    parameter int CLOCKS_PER_BAUD = CLOCKS_PER_BAUD_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic                 i_wr,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_empty,
    output logic                 o_idle,
    output logic                 uart_rxd_out
);
    localparam logic [TIMER_BITS-1:0] RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    uart_state_t state, state_n;
    logic [TIMER_BITS-1:0] baud, baud_n;
    logic [3:0] bit_cnt, bit_n;
    logic [DATA_BITS-1:0] sh, sh_n, head;
    logic full, pop, tick, line_n;
    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .i_reset_n(i_reset_n), .push(i_wr), .din(i_data),
        .pop(pop), .dout(head), .full(full), .empty(o_empty)
    );
    assign o_ready = !full;
    assign o_busy = state != IDLE;
    assign o_idle = o_empty && !o_busy;
    assign tick = baud == '0;
    always_ff @(posedge clk or negedge i_reset_n)
        if (!i_reset_n) begin
            state <= IDLE;
            baud <= '0;
            bit_cnt <= '0;
            sh <= '0;
            uart_rxd_out <= 1'b1;
        end else begin
            state <= state_n;
            baud <= baud_n;
            bit_cnt <= bit_n;
            sh <= sh_n;
            uart_rxd_out <= line_n;
        end
    always_comb begin
        state_n = state;
        baud_n = state == IDLE ? baud : tick ? RELOAD : baud - 1'b1;
        bit_n = bit_cnt;
        sh_n = sh;
        pop = 1'b0;
        case (state)
            IDLE: pop = !o_empty;
            START: state_n = tick ? DATA : START;
            DATA: if (tick) begin
                sh_n = sh >> 1;
                bit_n = bit_cnt == 4'(DATA_BITS - 1) ? 4'd0 : bit_cnt + 4'd1;
                state_n = bit_cnt == 4'(DATA_BITS - 1) ? STOP : DATA;
            end
            STOP: if (tick) begin
                bit_n = bit_cnt + 4'd1;
                if (bit_cnt == 4'(STOP_BITS - 1)) begin
                    pop = !o_empty;
                    state_n = IDLE;
                end
            end
        endcase
        // a pop from IDLE or the last stop cycle starts the next frame with no gap
        if (pop) begin
            sh_n = head;
            bit_n = '0;
            baud_n = RELOAD;
            state_n = START;
        end
        line_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
    end
endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart: random and directed stimulus checked against a waveform-queue UART model
module tb_tx_uart;
    localparam int CPB = 16, DEPTH = 4, FRAME = 10 * CPB;
    logic clk = 0, rst_n = 0, wr = 0, wr2 = 0;
    logic [7:0] data = 0;
    logic [6:0] data2 = 0;
    logic ready, busy, empty, idle, line;
    logic ready2, busy2, empty2, idle2, line2;
    int checks = 0, errors = 0, busy_cyc = 0, rk = 0;
    logic [7:0] mq[$], acc[$], rxq[$];
    logic mwave[$];
    logic [7:0] m_b, rb;
    logic ract = 0;
    always #5 clk = ~clk;

    tx_uart #(.DATA_BITS(8), .STOP_BITS(1), .CLOCKS_PER_BAUD(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_data(data), .o_ready(ready),
        .o_busy(busy), .o_empty(empty), .o_idle(idle), .uart_rxd_out(line));
    tx_uart #(.DATA_BITS(7), .STOP_BITS(2), .CLOCKS_PER_BAUD(8), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .i_reset_n(rst_n), .i_wr(wr2), .i_data(data2), .o_ready(ready2),
        .o_busy(busy2), .o_empty(empty2), .o_idle(idle2), .uart_rxd_out(line2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // model: each cycle consumes one expected line value; a new frame is queued when the previous one is used up
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mq.delete();
            mwave.delete();
        end else begin
            logic rdy;
            rdy = mq.size() < DEPTH;
            if (mwave.size() > 0) void'(mwave.pop_front());
            if (mwave.size() == 0 && mq.size() > 0) begin
                m_b = mq.pop_front();
                for (int i = 0; i < 10; i++)
                    for (int c = 0; c < CPB; c++)
                        mwave.push_back(i == 0 ? 1'b0 : i == 9 ? 1'b1 : m_b[i-1]);
            end
            if (wr && rdy) begin
                mq.push_back(data);
                acc.push_back(data);
            end
        end
        chk("line", line, mwave.size() > 0 ? mwave[0] : 1'b1);
        chk("busy", busy, mwave.size() > 0);
        chk("empty", empty, mq.size() == 0);
        chk("ready", ready, mq.size() < DEPTH);
        chk("idle", idle, mq.size() == 0 && mwave.size() == 0);
        if (busy) busy_cyc++;
    end

    // independent mid-bit sampling receiver
    initial forever begin
        @(negedge clk);
        if (!rst_n) ract = 0;
        else if (!ract) begin
            if (line === 1'b0) begin
                ract = 1;
                rk = 0;
            end
        end else begin
            rk++;
            if (rk % CPB == CPB / 2) begin
                if (rk / CPB >= 1 && rk / CPB <= 8) rb[rk/CPB-1] = line;
                if (rk / CPB == 9) begin
                    chk("rx_stop", line, 1);
                    rxq.push_back(rb);
                    ract = 0;
                end
            end
        end
    end

    task automatic put(input logic [7:0] b);
        int n;
        n = 0;
        wr = 1;
        data = b;
        while (!ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 2000) timeout("put");
        @(negedge clk);
        #1;
        wr = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!idle && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 5000) timeout("wait_idle");
    endtask

    initial begin
        logic [9:0] a5_bits, u2_bits;
        logic [7:0] burst[5];
        a5_bits = 10'b1101001010;
        u2_bits = 10'b1110000010;
        burst = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F};
        repeat (3) @(negedge clk);
        #1;
        chk("rst_line", line, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_idle", idle, 1);
        rst_n = 1;
        repeat (1000) @(negedge clk);
        #1;
        chk("idle_line", line, 1);
        chk("idle_ready", ready, 1);
        chk("idle_idle", idle, 1);

        rxq.delete();
        busy_cyc = 0;
        put(8'hA5);
        chk("a5_pre", line, 1);
        for (int j = 1; j <= FRAME + 1; j++) begin
            @(negedge clk);
            if (j == 1) chk("a5_latency", line, 0);
            if ((j - 1) % CPB == CPB / 2) chk("a5_bit", line, a5_bits[(j-1)/CPB]);
            if (j == FRAME) chk("a5_idle_late", idle, 0);
            if (j == FRAME + 1) chk("a5_idle_back", idle, 1);
        end
        #1;
        chk("a5_busy_cycles", busy_cyc, FRAME);
        chk("a5_rx_count", rxq.size(), 1);
        chk("a5_rx_byte", rxq[0], 8'hA5);

        rxq.delete();
        busy_cyc = 0;
        for (int i = 0; i < 5; i++) put(burst[i]);
        chk("burst_full", ready, 0);
        wr = 1;
        data = 8'hEE;
        repeat (20) begin
            @(negedge clk);
            #1;
            chk("full_hold", ready, 0);
        end
        wr = 0;
        wait_idle();
        chk("burst_busy_cycles", busy_cyc, 5 * FRAME);
        chk("burst_rx_count", rxq.size(), 5);
        for (int i = 0; i < 5; i++) chk("burst_rx_byte", rxq[i], burst[i]);

        rxq.delete();
        acc.delete();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 250)) @(negedge clk);
            #1;
            put(8'($urandom));
        end
        wait_idle();
        chk("rand_rx_count", rxq.size(), acc.size());
        for (int i = 0; i < acc.size() && i < rxq.size(); i++) chk("rand_rx_byte", rxq[i], acc[i]);

        rxq.delete();
        put(8'h33);
        put(8'h11);
        put(8'h22);
        repeat (50) @(posedge clk);
        #1;
        chk("pre_reset_line", line, 0);
        #2;
        rst_n = 0;
        #1;
        chk("async_reset_line", line, 1);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1;
        repeat (300) @(negedge clk);
        #1;
        chk("post_reset_empty", empty, 1);
        chk("post_reset_line", line, 1);
        chk("post_reset_rx", rxq.size(), 0);

        wr2 = 1;
        data2 = 7'h41;
        @(negedge clk);
        #1;
        wr2 = 0;
        for (int j = 1; j <= 81; j++) begin
            @(negedge clk);
            if (j == 1) chk("u2_latency", line2, 0);
            if ((j - 1) % 8 == 4) chk("u2_bit", line2, u2_bits[(j-1)/8]);
            if (j == 80) chk("u2_busy_late", busy2, 1);
            if (j == 81) chk("u2_busy_end", busy2, 0);
        end
        chk("u2_idle", idle2, 1);
        chk("u2_ready", ready2, 1);
        chk("u2_empty", empty2, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        timeout("watchdog");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
